seq_stim_gen: RTL and testbench

Command-driven stimulus sequencer that sits directly upstream of the `Main` FF stage and drives its `I` and `arr[1:0]` inputs. It accepts burst commands over a valid/ready interface and buffers them in a small FIFO. It plays each command out as a marker pair (`arr[0]`, then `arr[1]` exactly one cycle later), followed by a data run on `I` and an idle gap. By construction its outputs satisfy both downstream properties: `arr[0] |-> ##1 arr[1]`, and `I` is registered so the FF stage sees clean single-clock transitions.

---
 rtl/seq_stim_pkg.sv | 22 ++
 rtl/seq_stim_fifo.sv | 48 ++++
 rtl/seq_stim_gen.sv | 132 +++++++++++++
 tb/tb_seq_stim_gen.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_stim_pkg.sv
// seq_stim_pkg: shared types for the stimulus sequencer.
//   CMD_CNT_W : width of the length/gap fields carried in a command
//   state_t   : playback FSM states
//   cmd_t     : one buffered burst command {len, gap, data}
package seq_stim_pkg;

  localparam int CMD_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MARK = 2'd1,
    RUN  = 2'd2,
    GAP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [CMD_CNT_W-1:0] len;
    logic [CMD_CNT_W-1:0] gap;
    logic                 data;
  } cmd_t;

endpackage

// File: rtl/seq_stim_fifo.sv
// seq_stim_fifo: DEPTH-entry synchronous command FIFO.
//   CLK, ASYNCRESETN : clock, asynchronous active-low reset (empties the FIFO)
//   push, din        : write din at the tail (caller guarantees !full)
//   pop              : advance the head (caller guarantees !empty)
//   head             : command at the head, valid while !empty
//   full, empty      : occupancy flags
module seq_stim_fifo
  import seq_stim_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic CLK,
  input  logic ASYNCRESETN,
  input  logic push,
  input  cmd_t din,
  input  logic pop,
  output cmd_t head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_q;
  logic [AW:0] rd_q;
  cmd_t        mem [DEPTH];

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + (AW+1)'(1);
      if (pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_q[AW-1:0]] <= din;
  end

  assign head  = mem[rd_q[AW-1:0]];
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

endmodule

// File: rtl/seq_stim_gen.sv
// seq_stim_gen: command-driven stimulus sequencer for the Main FF stage.
// Each buffered command plays out as MARK (arr=01), a RUN of max(len,1)
// cycles driving I=data (arr=10 on the first cycle only), then gap idle cycles.
//   CLK, ASYNCRESETN      : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   : command handshake
//   cmd_len/cmd_gap/data  : command fields
//   I, arr                : registered stimulus outputs
//   busy                  : FSM active or commands pending
//   done                  : high during the final cycle of each command
// CNT_W must match seq_stim_pkg::CMD_CNT_W since commands are stored as cmd_t.
module seq_stim_gen
  import seq_stim_pkg::*;
#(
  parameter int CNT_W = CMD_CNT_W,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic [CNT_W-1:0] cmd_gap,
  input  logic             cmd_data,
  output logic             I,
  output logic [1:0]       arr,
  output logic             busy,
  output logic             done
);

  // Counter load for the RUN phase: a zero length still plays one cycle.
  function automatic logic [CNT_W-1:0] run_load(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : len - CNT_W'(1);
  endfunction

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] gap_q;
  logic             data_q;
  logic             rdy_q;
  logic             i_q;
  logic [1:0]       arr_q;

  cmd_t wr_cmd;
  cmd_t head;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic last_c;

  assign wr_cmd = '{len: cmd_len, gap: cmd_gap, data: cmd_data};

  // rdy_q holds cmd_ready low throughout reset and for the release cycle.
  assign cmd_ready = rdy_q && !full;
  assign push      = cmd_valid && cmd_ready;

  // Final cycle of a command: end of RUN with no gap, or end of GAP.
  assign last_c = ((state_q == RUN) && (cnt_q == '0) && (gap_q == '0)) ||
                  ((state_q == GAP) && (cnt_q == '0));

  // Popping in the final cycle chains commands with no IDLE cycle between.
  assign pop  = !empty && ((state_q == IDLE) || last_c);
  assign busy = (state_q != IDLE) || !empty;
  assign done = last_c;
  assign I    = i_q;
  assign arr  = arr_q;

  seq_stim_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .push        (push),
    .din         (wr_cmd),
    .pop         (pop),
    .head        (head),
    .full        (full),
    .empty       (empty)
  );

  // I and arr are registered with the values of the state being entered,
  // so they line up with the FSM state they describe.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      gap_q   <= '0;
      data_q  <= 1'b0;
      rdy_q   <= 1'b0;
      i_q     <= 1'b0;
      arr_q   <= 2'b00;
    end else begin
      rdy_q <= 1'b1;
      i_q   <= 1'b0;
      arr_q <= 2'b00;
      case (state_q)
        IDLE: ;
        MARK: begin
          state_q <= RUN;
          cnt_q   <= run_load(len_q);
          i_q     <= data_q;
          arr_q   <= 2'b10;
        end
        RUN: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
            i_q   <= data_q;
          end else if (gap_q != '0) begin
            state_q <= GAP;
            cnt_q   <= gap_q - CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
        end
        default: state_q <= IDLE;
      endcase
      if (last_c) state_q <= IDLE;
      // A pop overrides the finish transition above and starts the next command.
      if (pop) begin
        len_q   <= head.len;
        gap_q   <= head.gap;
        data_q  <= head.data;
        state_q <= MARK;
        arr_q   <= 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_seq_stim_gen.sv
module tb_seq_stim_gen;

  logic       CLK = 1'b0;
  logic       ASYNCRESETN = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_len = '0;
  logic [7:0] cmd_gap = '0;
  logic       cmd_data = 1'b0;
  logic       cmd_ready;
  logic       I;
  logic [1:0] arr;
  logic       busy;
  logic       done;

  always #5 CLK = ~CLK;

  seq_stim_gen #(
    .CNT_W (8),
    .DEPTH (4)
  ) dut (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_len     (cmd_len),
    .cmd_gap     (cmd_gap),
    .cmd_data    (cmd_data),
    .I           (I),
    .arr         (arr),
    .busy        (busy),
    .done        (done)
  );

  typedef struct {
    int len;
    int gap;
    bit data;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: each MARK pops one expected command, then every following cycle
  // of that command is compared as {I, arr, done}; idle cycles must be quiet.
  bit   m_active = 0;
  int   m_idx = 0;
  exp_t m_cur;
  int   cyc = 0;
  bit   expect_b2b = 0;
  bit   have_done = 0;
  int   last_done_cyc = 0;

  always @(negedge CLK) begin
    int n;
    logic [3:0] expv;
    cyc++;
    if (!ASYNCRESETN) begin
      m_active = 0;
    end else if (!m_active) begin
      if (arr == 2'b01) begin
        if (expect_b2b && have_done) check("b2b_gap", cyc - last_done_cyc, 1);
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_mark: got MARK, expected no command");
        end else begin
          m_cur    = sb.pop_front();
          m_active = 1;
          m_idx    = 0;
          check("mark_out", {I, done}, 0);
        end
      end else begin
        check("idle_out", {I, arr, done}, 0);
      end
    end else begin
      m_idx++;
      n    = (m_cur.len == 0) ? 1 : m_cur.len;
      expv = {(m_idx <= n) ? m_cur.data : 1'b0,
              (m_idx == 1) ? 2'b10 : 2'b00,
              (m_idx == n + m_cur.gap)};
      check("play_out", {I, arr, done}, expv);
      if (m_idx == n + m_cur.gap) begin
        m_active      = 0;
        have_done     = 1;
        last_done_cyc = cyc;
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accept edge.
  // pd reports the done value in the last cycle spent waiting for ready.
  task automatic push(input int len, input int gap, input bit data, output bit pd);
    int t = 0;
    exp_t e;
    pd        = 1'b0;
    cmd_valid = 1'b1;
    cmd_len   = len[7:0];
    cmd_gap   = gap[7:0];
    cmd_data  = data;
    while (!cmd_ready && t < 2000) begin
      pd = done;
      @(negedge CLK);
      t++;
    end
    if (!cmd_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_timeout: got cmd_ready=0, expected 1");
      cmd_valid = 1'b0;
    end else begin
      e.len = len; e.gap = gap; e.data = data;
      sb.push_back(e);
      @(negedge CLK);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || sb.size() != 0 || m_active) && t < 5000) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 5000) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout: got busy=%0d, expected 0", busy);
    end
    @(negedge CLK);
  endtask

  initial begin
    bit pd;
    #1;
    check("reset_vals", {I, arr, done, busy, cmd_ready}, 0);
    @(negedge CLK);
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    #1;
    check("ready_pre_edge", cmd_ready, 0);
    @(negedge CLK);
    check("ready_after_rst", cmd_ready, 1);

    // Single command {3,2,1}: latency and done position.
    push(3, 2, 1'b1, pd);
    check("lat_t1_arr", arr, 2'b00);
    check("lat_t1_busy", busy, 1);
    @(negedge CLK);
    check("lat_mark", arr, 2'b01);
    repeat (5) @(negedge CLK);
    check("done_t7", done, 1);
    @(negedge CLK);
    check("busy_after", busy, 0);
    wait_idle();

    // Zero length, zero gap: one RUN cycle that is also the done cycle.
    push(0, 0, 1'b1, pd);
    wait_idle();

    // Back-to-back: fill the FIFO, then one accept per done.
    have_done  = 0;
    expect_b2b = 1;
    for (int i = 0; i < 5; i++) push(6, 1, i[0], pd);
    check("full_ready", cmd_ready, 0);
    check("full_busy", busy, 1);
    push(2, 0, 1'b1, pd);
    check("ready_after_done", pd, 1);
    wait_idle();
    expect_b2b = 0;

    // Asynchronous reset mid-RUN with a second command queued.
    push(10, 3, 1'b1, pd);
    push(5, 0, 1'b1, pd);
    repeat (3) @(negedge CLK);
    #2;
    ASYNCRESETN = 1'b0;
    #1;
    check("async_rst", {I, arr, done, busy, cmd_ready}, 0);
    sb.delete();
    @(negedge CLK);
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    repeat (30) @(negedge CLK);
    check("no_stale", busy, 0);

    // Longest run length.
    push(255, 0, 1'b1, pd);
    wait_idle();

    // Random command stream with random idle spacing.
    for (int i = 0; i < 40; i++) begin
      push($urandom_range(0, 5), $urandom_range(0, 3), 1'($urandom_range(0, 1)), pd);
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
